eth_10g_block_lock: RTL
=======================

ETH_10G_BLOCK_LOCK -- requirements
Module: eth_10g_block_lock

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64: sync headers per test window.
REQ-002 SHALL have parameter SH_INVALID_MAX, default 16: invalid headers per window that drop lock.
REQ-003 SHALL have parameter SLIP_WAIT_CYCLES, default 32: minimum i_clk cycles after an o_rxslip pulse before header testing restarts.
REQ-004 SHALL have port i_clk, input, 1: GT RX user clock, the sole clock.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_rxdata, input, 32: GT gearbox data word.
REQ-007 SHALL have port i_rxdatavalid, input, 1: i_rxdata valid this cycle.
REQ-008 SHALL have port i_rxheader, input, 2: 64b/66b sync header.
REQ-009 SHALL have port i_rxheader_valid, input, 1: i_rxheader valid; marks first word of a block.
REQ-010 SHALL have port o_rxslip, output, 1: one-cycle slip request to GT.
REQ-011 SHALL have port o_block_lock, output, 1: block lock achieved.
REQ-012 SHALL have port o_block_data, output, 64: assembled block, first word in [31:0].
REQ-013 SHALL have port o_block_header, output, 2: header of o_block_data.
REQ-014 SHALL have port o_block_valid, output, 1: one-cycle strobe qualifying o_block_data/o_block_header.
REQ-015 SHALL have port o_slip_count, output, 16: saturating count of slips issued, for debug.

Function
REQ-016 SHALL classify a header as valid only if it equals 2'b01 (data) or 2'b10 (control); 2'b00 and 2'b11 are invalid.
REQ-017 SHALL implement FSM states RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
REQ-018 RESET_CNT SHALL clear sh_cnt and sh_invalid_cnt and go to TEST_SH next cycle.
REQ-019 TEST_SH SHALL, on each cycle with i_rxheader_valid=1, increment sh_cnt and, if the header is invalid, increment sh_invalid_cnt; cycles without i_rxheader_valid change nothing.
REQ-020 When unlocked, an invalid header in TEST_SH SHALL go to SLIP immediately.
REQ-021 When unlocked, sh_cnt reaching SH_CNT_MAX with zero invalids SHALL set o_block_lock=1 and go to RESET_CNT.
REQ-022 When locked, sh_invalid_cnt reaching SH_INVALID_MAX SHALL clear o_block_lock and go to SLIP, even if sh_cnt reaches SH_CNT_MAX on the same header.
REQ-023 When locked, sh_cnt reaching SH_CNT_MAX with sh_invalid_cnt < SH_INVALID_MAX SHALL keep lock and go to RESET_CNT.
REQ-024 SLIP SHALL assert o_rxslip for exactly one cycle, increment o_slip_count (saturating at 16'hFFFF), and go to SLIP_WAIT.
REQ-025 SLIP_WAIT SHALL count SLIP_WAIT_CYCLES cycles, ignoring all inputs, then go to RESET_CNT.
REQ-026 Counters SHALL be sized $clog2(max+1) bits; no wrap-around is possible.
REQ-027 Block assembly: a cycle with i_rxdatavalid=1 and i_rxheader_valid=1 SHALL capture i_rxdata into [31:0] and i_rxheader; the next cycle with i_rxdatavalid=1 and i_rxheader_valid=0 SHALL capture [63:32].
REQ-028 o_block_valid SHALL pulse exactly one cycle after the second word is captured, only if o_block_lock=1 on that capture cycle.
REQ-029 A new header-valid word arriving while the second word is awaited SHALL discard the partial block and start a new one.
REQ-030 A non-header word arriving when no first word is held SHALL be dropped.
REQ-031 Cycles with i_rxdatavalid=0 SHALL hold assembly state.
REQ-032 Entering SLIP SHALL discard any partial block.

Reset
REQ-033 On i_rst=1 at a rising edge, SHALL enter RESET_CNT; o_rxslip=0, o_block_lock=0, o_block_valid=0, o_slip_count=0, o_block_data=0, o_block_header=0, partial block cleared.
REQ-034 Reset asserted mid-SLIP_WAIT or mid-block SHALL abort it with no further o_rxslip or o_block_valid.

Structure
REQ-035 Package eth_10g_pkg SHALL hold SYNC_HDR_DATA=2'b01, SYNC_HDR_CTRL=2'b10 and the block-lock state enum.
REQ-036 Word-pair assembly SHALL be sub-module eth_10g_block_assembler; lock FSM and counters stay in the top.

Verification
REQ-037 Reset, then 64 blocks with header 2'b01 -> o_block_lock rises after the 64th header, o_rxslip never asserted.
REQ-038 Unlocked, header 2'b11 on 5th block -> one o_rxslip pulse next cycle, o_slip_count=1, no header counted for 32 cycles after.
REQ-039 Locked, 15 invalid headers in 64-header window -> lock held; 16 invalid in a window -> lock drops, one o_rxslip.
REQ-040 Locked, words 0x11111111(hdr 2'b10) then 0x22222222 -> o_block_valid once, o_block_data=0x2222222211111111, o_block_header=2'b10.
REQ-041 Two consecutive header-valid words (A, B) then word C -> one block {C,B}, A discarded.
REQ-042 i_rst asserted during SLIP_WAIT -> all outputs zero next cycle, counters restart from RESET_CNT.

Source files
------------

// File: rtl/eth_10g_pkg.sv
// eth_10g_pkg: sync-header constants, block-lock state type and header check
package eth_10g_pkg;
  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;
  typedef enum logic [1:0] {RESET_CNT, TEST_SH, SLIP, SLIP_WAIT} lock_state_e;
  function automatic logic hdr_ok(input logic [1:0] hdr);
    return hdr == SYNC_HDR_DATA || hdr == SYNC_HDR_CTRL;
  endfunction
endpackage

// File: rtl/eth_10g_block_assembler.sv
// eth_10g_block_assembler: pairs 32-bit gearbox words into 64-bit blocks with their header
module eth_10g_block_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_lock,
  input  logic [31:0] i_rxdata,
  input  logic        i_rxdatavalid,
  input  logic [1:0]  i_rxheader,
  input  logic        i_rxheader_valid,
  output logic [63:0] o_block_data,
  output logic [1:0]  o_block_header,
  output logic        o_block_valid
);
  logic        have_q, have_d, valid_q, valid_d;
  logic [31:0] first_q, first_d;
  logic [1:0]  first_hdr_q, first_hdr_d, hdr_q, hdr_d;
  logic [63:0] data_q, data_d;
  always_comb begin
    have_d      = have_q;
    first_d     = first_q;
    first_hdr_d = first_hdr_q;
    data_d      = data_q;
    hdr_d       = hdr_q;
    valid_d     = 1'b0;
    if (i_flush) have_d = 1'b0;
    else if (i_rxdatavalid && i_rxheader_valid) begin
      have_d      = 1'b1;
      first_d     = i_rxdata;
      first_hdr_d = i_rxheader;
    end else if (i_rxdatavalid && have_q) begin
      have_d  = 1'b0;
      data_d  = {i_rxdata, first_q};
      hdr_d   = first_hdr_q;
      valid_d = i_lock;
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      have_q      <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= '0;
      first_hdr_q <= '0;
      data_q      <= '0;
      hdr_q       <= '0;
    end else begin
      have_q      <= have_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      first_hdr_q <= first_hdr_d;
      data_q      <= data_d;
      hdr_q       <= hdr_d;
    end
  assign o_block_data   = data_q;
  assign o_block_header = hdr_q;
  assign o_block_valid  = valid_q;
endmodule

// File: rtl/eth_10g_block_lock.sv
// eth_10g_block_lock: 64b/66b sync-header block lock FSM with gearbox slip control
module eth_10g_block_lock
  import eth_10g_pkg::*;
#(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_rxdata,
  input  logic        i_rxdatavalid,
  input  logic [1:0]  i_rxheader,
  input  logic        i_rxheader_valid,
  output logic        o_rxslip,
  output logic        o_block_lock,
  output logic [63:0] o_block_data,
  output logic [1:0]  o_block_header,
  output logic        o_block_valid,
  output logic [15:0] o_slip_count
);
  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SH_CNT_MAX);
  localparam logic [IW-1:0] INV_MAX = IW'(SH_INVALID_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT_CYCLES - 1);
  lock_state_e   state_q, state_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d, cnt_n;
  logic [IW-1:0] sh_inv_q, sh_inv_d, inv_n;
  logic [WW-1:0] wait_q, wait_d;
  logic          lock_q, lock_d;
  logic [15:0]   slip_cnt_q, slip_cnt_d;
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    sh_inv_d   = sh_inv_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    slip_cnt_d = slip_cnt_q;
    cnt_n      = sh_cnt_q + CW'(1);
    inv_n      = sh_inv_q + IW'(!hdr_ok(i_rxheader));
    case (state_q)
      RESET_CNT: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        state_d  = TEST_SH;
      end
      TEST_SH: if (i_rxheader_valid) begin
        sh_cnt_d = cnt_n;
        sh_inv_d = inv_n;
        if (lock_q) begin
          if (inv_n == INV_MAX) begin
            lock_d  = 1'b0;
            state_d = SLIP;
          end else if (cnt_n == CNT_MAX) state_d = RESET_CNT;
        end else if (!hdr_ok(i_rxheader)) state_d = SLIP;
        else if (cnt_n == CNT_MAX) begin
          lock_d  = 1'b1;
          state_d = RESET_CNT;
        end
      end
      SLIP: begin
        slip_cnt_d = slip_cnt_q == 16'hFFFF ? slip_cnt_q : slip_cnt_q + 16'd1;
        wait_d     = '0;
        state_d    = SLIP_WAIT;
      end
      default: begin
        wait_d  = wait_q + WW'(1);
        state_d = wait_q == WAIT_LAST ? RESET_CNT : SLIP_WAIT;
      end
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q    <= RESET_CNT;
      sh_cnt_q   <= '0;
      sh_inv_q   <= '0;
      wait_q     <= '0;
      lock_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_inv_q   <= sh_inv_d;
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      slip_cnt_q <= slip_cnt_d;
    end
  assign o_rxslip     = state_q == SLIP;
  assign o_block_lock = lock_q;
  assign o_slip_count = slip_cnt_q;
  eth_10g_block_assembler u_asm (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_flush          (state_q == SLIP),
    .i_lock           (lock_q),
    .i_rxdata         (i_rxdata),
    .i_rxdatavalid    (i_rxdatavalid),
    .i_rxheader       (i_rxheader),
    .i_rxheader_valid (i_rxheader_valid),
    .o_block_data     (o_block_data),
    .o_block_header   (o_block_header),
    .o_block_valid    (o_block_valid)
  );
endmodule
